// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, BCD digit
// limits and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] minutes;
    logic [3:0] tens;
    logic [3:0] units;
    logic [3:0] tenths;
  } time_t;

  localparam logic [3:0] TENTHS_MAX  = 4'd9;
  localparam logic [3:0] UNITS_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;
  localparam logic [3:0] MINUTES_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: button edge detection, IDLE/RUN/PAUSED/STOPPED control, a BCD
// m:ss.t counter advanced by tick, and a multiplexed 4-digit display scan.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start_e,
  input  logic       pause_e,
  input  logic       stop_e,
  input  logic       clear_e,
  output logic [6:0] seg,
  output logic [3:0] pos,
  output logic       run
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  // Button order in the vectors below: {clear, stop, pause, start}
  logic [3:0] btn_in;
  logic [3:0] btn_q, btn_prev_q;
  logic       armed_q;
  logic [3:0] press;

  state_t     state_q, state_d;
  time_t      time_q, time_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          refresh_tc;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    pos_onehot;

  assign btn_in = {clear_e, stop_e, pause_e, start_e};

  // The first edge after reset primes both stages with the live level, so a
  // button already held through reset release never reads as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q      <= '0;
      btn_prev_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      btn_q      <= btn_in;
      btn_prev_q <= armed_q ? btn_q : btn_in;
      armed_q    <= 1'b1;
    end
  end

  assign press = btn_q & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    if (press[3]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (press[0]) state_d = ST_RUN;
        ST_RUN:     if (press[2]) state_d = ST_STOPPED;
                    else if (press[1]) state_d = ST_PAUSED;
        ST_PAUSED:  if (press[2]) state_d = ST_STOPPED;
                    else if (press[0]) state_d = ST_RUN;
        ST_STOPPED: state_d = ST_STOPPED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    time_d = time_q;
    if (press[3]) begin
      time_d = '0;
    end else if (tick && (state_q == ST_RUN)) begin
      if (time_q.tenths != TENTHS_MAX) begin
        time_d.tenths = time_q.tenths + 4'd1;
      end else begin
        time_d.tenths = 4'd0;
        if (time_q.units != UNITS_MAX) begin
          time_d.units = time_q.units + 4'd1;
        end else begin
          time_d.units = 4'd0;
          if (time_q.tens != TENS_MAX) begin
            time_d.tens = time_q.tens + 4'd1;
          end else begin
            time_d.tens    = 4'd0;
            time_d.minutes = (time_q.minutes == MINUTES_MAX) ? 4'd0
                                                             : time_q.minutes + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
    end
  end

  assign run = (state_q == ST_RUN);

  assign refresh_tc = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d  = refresh_tc ? '0 : cnt_q + 1'b1;
    slot_d = refresh_tc ? slot_q + 2'd1 : slot_q;
  end

  always_comb begin
    digit = time_q.tenths;
    case (slot_q)
      2'd0: digit = time_q.tenths;
      2'd1: digit = time_q.units;
      2'd2: digit = time_q.tens;
      2'd3: digit = time_q.minutes;
      default: digit = time_q.tenths;
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd_i (digit),
    .seg_o (seg_dec)
  );

  always_comb begin
    pos_onehot = 4'b0001 << slot_q;
    seg_d      = seg_dec;
    pos_d      = ~pos_onehot;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      slot_q <= 2'd0;
      seg_q  <= SEG_BLANK;
      pos_q  <= 4'b1111;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      seg_q  <= seg_d;
      pos_q  <= pos_d;
    end
  end

  assign seg = seg_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random button/tick traffic
// checked against a tenths-count reference model via the multiplexed display.
module tb_stopwatch_core;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_STOPPED = 3;
  localparam int FULL_SCALE = 6000;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       start_e, pause_e, stop_e, clear_e;
  logic [6:0] seg;
  logic [3:0] pos;
  logic       run;

  int n_checks;
  int n_fail;
  int m_state;
  int m_total;
  logic [27:0] exp_q[$];

  stopwatch_core #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .start_e (start_e),
    .pause_e (pause_e),
    .stop_e  (stop_e),
    .clear_e (clear_e),
    .seg     (seg),
    .pos     (pos),
    .run     (run)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic void model_press(input logic [3:0] b);
    if (b[3]) begin
      m_state = M_IDLE;
      m_total = 0;
    end else if (b[2] && (m_state == M_RUN || m_state == M_PAUSED)) begin
      m_state = M_STOPPED;
    end else if (b[1] && m_state == M_RUN) begin
      m_state = M_PAUSED;
    end else if (b[0] && (m_state == M_IDLE || m_state == M_PAUSED)) begin
      m_state = M_RUN;
    end
  endfunction

  function automatic void model_tick();
    if (m_state == M_RUN) m_total = (m_total + 1) % FULL_SCALE;
  endfunction

  // drivers: b = {clear, stop, pause, start}
  task automatic press(input logic [3:0] b);
    if (b[0]) start_e = 1'b1;
    if (b[1]) pause_e = 1'b1;
    if (b[2]) stop_e  = 1'b1;
    if (b[3]) clear_e = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_press(b);
    if (b[0]) start_e = 1'b0;
    if (b[1]) pause_e = 1'b0;
    if (b[2]) stop_e  = 1'b0;
    if (b[3]) clear_e = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      model_tick();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_state = M_IDLE;
    m_total = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", seg, 7'b1111111);
    check("reset_pos", pos, 4'b1111);
    check("reset_run", run, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // scoreboard: capture one full display scan and compare with the model
  task automatic scan_display();
    logic [3:0]  prev;
    logic [3:0]  one_hot;
    logic [63:0] pos_obs, pos_exp;
    logic [27:0] seg_obs, seg_exp;
    int          d[4];
    bit          found;
    d[0] = m_total % 10;
    d[1] = (m_total / 10) % 10;
    d[2] = (m_total / 100) % 6;
    d[3] = m_total / 600;
    seg_exp = {seg_ref(d[3]), seg_ref(d[2]), seg_ref(d[1]), seg_ref(d[0])};
    exp_q.push_back(seg_exp);
    found = 1'b0;
    @(negedge clk);
    prev = pos;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pos == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = pos;
    end
    if (!found) begin
      check("scan_sync", 1'b0, 1'b1);
      void'(exp_q.pop_front());
    end else begin
      pos_obs = '0;
      pos_exp = '0;
      seg_obs = '0;
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clk);
        pos_obs[i*4 +: 4] = pos;
        one_hot = 4'b0001 << (i / 4);
        pos_exp[i*4 +: 4] = ~one_hot;
        if (i % 4 == 1) seg_obs[(i/4)*7 +: 7] = seg;
      end
      check("pos_scan", pos_obs, pos_exp);
      check("display", seg_obs, exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tick     = 1'b0;
    start_e  = 1'b1;  // held through reset: must not register as a press
    pause_e  = 1'b0;
    stop_e   = 1'b0;
    clear_e  = 1'b0;
    reset_n  = 1'b0;

    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check("held_start_no_press", run, 1'b0);
    start_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    scan_display();

    // start, 10 ticks -> 0:01.0
    press(4'b0001);
    ticks(10);
    check("run_after_start", run, m_state == M_RUN);
    scan_display();

    // pause holds, resume continues
    ticks(24);
    scan_display();
    press(4'b0010);
    check("run_paused", run, 1'b0);
    ticks(5);
    scan_display();
    press(4'b0001);
    ticks(1);
    scan_display();

    // carries and full wrap
    press(4'b1000);
    press(4'b0001);
    ticks(599);
    scan_display();
    ticks(1);
    scan_display();
    ticks(5399);
    scan_display();
    ticks(1);
    scan_display();
    check("run_after_wrap", run, 1'b1);

    // stop+pause+start together -> STOPPED, then frozen
    ticks(7);
    press(4'b0111);
    check("run_stopped", run, 1'b0);
    press(4'b0001);
    ticks(10);
    check("run_still_stopped", run, 1'b0);
    scan_display();

    // clear coincident with a counted tick, start held throughout
    press(4'b1000);
    press(4'b0001);
    ticks(3);
    start_e = 1'b1;
    @(posedge clk); #1;
    clear_e = 1'b1;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    clear_e = 1'b0;
    model_press(4'b1000);
    check("clear_tick_run", run, 1'b0);
    ticks(10);
    check("held_start_no_restart", run, 1'b0);
    scan_display();
    start_e = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-count
    press(4'b0001);
    ticks(50);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_seg", seg, 7'b1111111);
    check("async_pos", pos, 4'b1111);
    check("async_run", run, 1'b0);
    m_state = M_IDLE;
    m_total = 0;
    @(negedge clk);
    reset_n = 1'b1;
    scan_display();

    // random traffic
    for (int op = 0; op < 300; op++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 12)       ticks($urandom_range(1, 30));
      else if (sel < 15)  press(4'b0001);
      else if (sel < 17)  press(4'b0010);
      else if (sel < 19)  press(4'b0100);
      else                press(4'b1000);
      if (sel >= 12) check("rand_run", run, m_state == M_RUN);
      if (op % 25 == 24) scan_display();
    end
    scan_display();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001: Parameter REFRESH_DIV, default 50000: clk cycles per display digit slot; legal range 2..2^20.
REQ-002: clk  input  1  system clock; all state updates on its rising edge.
REQ-003: reset_n  input  1  asynchronous, active-low reset.
REQ-004: tick  input  1  one-cycle pulse every 0.1 s from the upstream prescaler.
REQ-005: start_e, pause_e, stop_e, clear_e  input  1 each  debounced button levels, active-high.
REQ-006: seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007: pos  output  4  digit enable, active-low one-hot; pos[0] selects tenths, pos[1] seconds units, pos[2] seconds tens, pos[3] minutes.
REQ-008: run  output  1  high while the FSM is in RUN.

Function
REQ-009: Each button input shall be registered once and rising-edge detected; only a 0->1 transition shall count as a press, and a held level shall not repeat.
REQ-010: FSM states: IDLE, RUN, PAUSED, STOPPED.
REQ-011: IDLE + start -> RUN; RUN + pause -> PAUSED; PAUSED + start -> RUN; RUN or PAUSED + stop -> STOPPED; any state + clear -> IDLE with all digits zeroed.
REQ-012: All other event/state combinations shall be ignored; in STOPPED, start and pause have no effect.
REQ-013: Events detected in the same cycle shall resolve by priority clear > stop > pause > start, with exactly one transition taken.
REQ-014: Time advances on a tick only when the registered state is RUN in that cycle; a transition takes effect from the next cycle.
REQ-015: Time is held as four BCD digits: tenths 0-9, seconds units 0-9, seconds tens 0-5, minutes 0-9.
REQ-016: Carry chain: tenths 9->0 increments seconds units; units 9->0 increments tens; tens 5->0 increments minutes.
REQ-017: At 9:59.9, a counted tick shall wrap all digits to 0:00.0; the state stays RUN.
REQ-018: If clear and tick occur in the same cycle, clear shall win and the digits shall read 0:00.0 next cycle.
REQ-019: A free-running refresh counter shall advance the digit slot 0->1->2->3->0 once every REFRESH_DIV cycles, independent of FSM state.
REQ-020: seg and pos shall be registered; their latency is one cycle after a digit-slot change.
REQ-021: Decoding is active-low: 0=1000000, 1=1111001, 5=0010010, 9=0010000.
REQ-022: Every digit position shows its digit at all times, including leading zeros.

Reset
REQ-023: While reset_n is low, the FSM shall be IDLE, all digits and the refresh counter 0, edge-detect registers 0, digit slot 0.
REQ-024: Outputs during reset: seg=1111111, pos=1111, run=0.
REQ-025: A button already held high when reset releases shall not produce a press.
REQ-026: Reset asserted mid-count shall discard the time immediately, with no clock required.

Structure
REQ-027: Package stopwatch_pkg shall hold the FSM state typedef, the digit maximum constants (9, 9, 5, 9), and the active-low segment pattern constants.
REQ-028: The BCD-to-7-segment decoder shall be one combinational sub-module, seg7_decode, used by stopwatch_core.
REQ-029: No clock gating: tick and the refresh terminal count are used only as clock enables.

Verification
REQ-030: Reset, then start press, then 10 ticks -> digits 0:01.0, run=1.
REQ-031: At 0:03.4 in RUN, pause press, then 5 ticks -> 0:03.4 held; start press, 1 tick -> 0:03.5.
REQ-032: Preload to 0:59.9 via ticks, one tick -> 1:00.0; at 9:59.9, one tick -> 0:00.0, still RUN.
REQ-033: In RUN, stop, pause and start pressed in the same cycle -> STOPPED; further start presses and ticks -> time frozen.
REQ-034: In RUN, clear coincident with tick -> next cycle IDLE, 0:00.0, run=0; with start held continuously, no restart.
REQ-035: REFRESH_DIV=4, time 1:23.4 -> pos cycles 1110, 1101, 1011, 0111 every 4 clks with seg = 4, 3, 2, 1 patterns; reset_n pulsed low mid-slot -> seg=1111111 and pos=1111 asynchronously.
